// File: rtl/axis_slave_byte_fifo.sv
// AXI-Stream slave word FIFO with an LSB-first byte serialiser for the 9x8 processor read port.
// Optional per-byte tkeep support is enabled by defining AXIS_SLAVE_BYTE_FIFO_TKEEP_EN.
module axis_slave_byte_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
`ifdef AXIS_SLAVE_BYTE_FIFO_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
`endif
  output logic [7:0]              o_byte,
  output logic                    o_byte_valid,
  input  logic                    i_byte_rd,
  output logic                    o_byte_last,
  output logic [CW-1:0]           o_words,
  input  logic                    i_flush
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef struct packed {
    logic [NB-1:0]         keep;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  entry_t        r_head;
  logic          r_head_valid;
  logic [IW-1:0] r_idx;

  logic          w_empty;
  logic          w_full;
  logic [NB-1:0] w_in_keep;
  entry_t        w_in_entry;
  entry_t        w_rd_entry;
  logic          w_store;
  logic [IW-1:0] w_first_idx;
  logic [IW-1:0] w_next_idx;
  logic          w_has_next;
  logic          w_pop_byte;
  logic          w_consume;
  logic          w_load;

`ifdef AXIS_SLAVE_BYTE_FIFO_TKEEP_EN
  assign w_in_keep = s_axis_tkeep;
`else
  assign w_in_keep = '1;
`endif

  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign s_axis_tready = ~w_full & ~i_flush & i_rst_n;

  // An all-zero keep without tlast carries nothing; it is handshaken and dropped.
  assign w_store    = s_axis_tvalid & s_axis_tready & ((|w_in_keep) | s_axis_tlast);
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_in_entry.keep = w_in_keep;
    w_in_entry.last = s_axis_tlast;
    w_in_entry.data = '0;
    for (int i = 0; i < NB; i++) begin
      if (w_in_keep[i]) w_in_entry.data[8*i +: 8] = s_axis_tdata[8*i +: 8];
    end
  end

  // Priority encoders: lowest kept byte of the word being loaded, next kept byte above r_idx.
  always_comb begin
    w_first_idx = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (w_rd_entry.keep[i]) w_first_idx = IW'(i);
    end
  end

  always_comb begin
    w_next_idx = r_idx;
    w_has_next = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (r_head.keep[i] && (i > int'(r_idx))) begin
        w_next_idx = IW'(i);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_pop_byte = r_head_valid & i_byte_rd;
  assign w_consume  = w_pop_byte & ~w_has_next;
  assign w_load     = (~r_head_valid | w_consume) & ~w_empty;

  // NOTE: storage array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= w_in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
      r_idx        <= '0;
    end else if (i_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head_valid <= 1'b0;
      r_idx        <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_head       <= w_rd_entry;
        r_head_valid <= 1'b1;
        r_idx        <= w_first_idx;
      end else if (w_consume) begin
        r_head_valid <= 1'b0;
        r_idx        <= '0;
      end else if (w_pop_byte) begin
        r_idx <= w_next_idx;
      end
    end
  end

  assign o_byte_valid = r_head_valid;
  assign o_byte       = r_head_valid ? r_head.data[8*r_idx +: 8] : 8'h00;
  assign o_byte_last  = r_head_valid & r_head.last & ~w_has_next;
  assign o_words      = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_axis_slave_byte_fifo.sv
// Self-checking bench for axis_slave_byte_fifo: table vectors, byte scoreboard and corner-case sequences.
module tb_axis_slave_byte_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [NB-1:0] tb_keep;
  logic [7:0]    o_byte;
  logic          o_byte_valid;
  logic          i_byte_rd;
  logic          o_byte_last;
  logic [CW-1:0] o_words;
  logic          i_flush;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic          last1;
  } vec_t;
  vec_t vecs[3];

  axis_slave_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdata (s_axis_tdata),
`ifdef AXIS_SLAVE_BYTE_FIFO_TKEEP_EN
    .s_axis_tkeep (tb_keep),
`endif
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_rd    (i_byte_rd),
    .o_byte_last  (o_byte_last),
    .o_words      (o_words),
    .i_flush      (i_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected byte stream of one accepted word: kept bytes low to high, last on the highest kept.
  task automatic push_word(input logic [DW-1:0] data, input logic last, input logic [NB-1:0] keep);
    int hi = -1;
    for (int i = 0; i < NB; i++) if (keep[i]) hi = i;
    if (hi < 0) begin
      if (last) sb.push_back({1'b1, 8'h00});
    end else begin
      for (int i = 0; i < NB; i++)
        if (keep[i]) sb.push_back({last && (i == hi), data[8*i +: 8]});
    end
  endtask

  // One clock: sample handshakes just before the edge, then return 1 time unit after it.
  task automatic tick();
    #3;
    if (s_axis_tvalid && s_axis_tready) push_word(s_axis_tdata, s_axis_tlast, tb_keep);
    if (o_byte_valid && i_byte_rd) begin
      if (sb.size() == 0) check("sb_unexpected_byte", {23'd0, o_byte_last, o_byte}, 32'h1ff);
      else check("sb_byte", {23'd0, o_byte_last, o_byte}, {23'd0, sb.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] data, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    i_byte_rd = 1'b1;
    for (int c = 0; c < budget && (o_byte_valid || o_words != 0); c++) tick();
    i_byte_rd = 1'b0;
    check("drain_valid", o_byte_valid, 0);
    check("drain_words", o_words, 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{data: 16'h0051, last: 1'b1, b0: 8'h51, b1: 8'h00, last1: 1'b1};
    vecs[1] = '{data: 16'hA55A, last: 1'b0, b0: 8'h5A, b1: 8'hA5, last1: 1'b0};
    vecs[2] = '{data: 16'hFF01, last: 1'b1, b0: 8'h01, b1: 8'hFF, last1: 1'b1};

    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    tb_keep = '1; i_byte_rd = 1'b0; i_flush = 1'b0;
    #2;
    check("rst_tready", s_axis_tready, 0);
    check("rst_valid", o_byte_valid, 0);
    check("rst_byte", o_byte, 0);
    check("rst_last", o_byte_last, 0);
    check("rst_words", o_words, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rel_tready", s_axis_tready, 1);
    @(posedge clk); #1;

    // Table vectors: one word, one-edge latency, then two pops.
    foreach (vecs[v]) begin
      send(vecs[v].data, vecs[v].last);
      check("vec_latency_valid", o_byte_valid, 0);
      check("vec_latency_words", o_words, 1);
      tick();
      check("vec_b0_valid", o_byte_valid, 1);
      check("vec_b0", o_byte, vecs[v].b0);
      check("vec_b0_last", o_byte_last, 0);
      i_byte_rd = 1'b1;
      tick();
      check("vec_b1", o_byte, vecs[v].b1);
      check("vec_b1_last", o_byte_last, vecs[v].last1);
      tick();
      i_byte_rd = 1'b0;
      check("vec_done_valid", o_byte_valid, 0);
    end

    // Pops while nothing is presented are ignored.
    i_byte_rd = 1'b1;
    tick(); tick();
    i_byte_rd = 1'b0;
    check("idle_rd_words", o_words, 0);
    send(16'h7766, 1'b1);
    tick();
    check("idle_rd_byte0", o_byte, 8'h66);
    drain(10);

    // Back-to-back: six bytes on six consecutive cycles.
    begin
      logic [7:0] exp_b[6];
      exp_b = '{8'h51, 8'h00, 8'h40, 8'h00, 8'h31, 8'h00};
      send(16'h0051, 1'b1);
      send(16'h0040, 1'b1);
      send(16'h0031, 1'b1);
      i_byte_rd = 1'b1;
      for (int i = 0; i < 6; i++) begin
        check("b2b_valid", o_byte_valid, 1);
        check("b2b_byte", o_byte, exp_b[i]);
        tick();
      end
      i_byte_rd = 1'b0;
      check("b2b_end_valid", o_byte_valid, 0);
      check("b2b_sb_empty", sb.size(), 0);
    end

    // Full: 17 words held (FIFO + head), then one word read frees exactly one slot.
    begin
      int acc = 0;
      int k;
      for (int c = 0; c < 25; c++) begin
        k = 9 - (acc % 10);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = DW'(k * k);
        s_axis_tlast  = (acc % 4 == 3);
        #3;
        if (s_axis_tready) acc++;
        #0;
        tick();
      end
      check("full_accepted", acc, 17);
      check("full_tready", s_axis_tready, 0);
      check("full_words", o_words, 16);
      i_byte_rd = 1'b1;
      tick(); tick();
      i_byte_rd = 1'b0;
      check("full_free_tready", s_axis_tready, 1);
      check("full_free_words", o_words, 15);
      tick();
      acc++;
      s_axis_tvalid = 1'b0;
      check("full_refill_tready", s_axis_tready, 0);
      check("full_refill_words", o_words, 16);
      drain(100);
    end

    // Flush with a word offered: not accepted, everything cleared, next word from byte 0.
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b1);
    i_byte_rd = 1'b1;
    tick();
    i_byte_rd = 1'b0;
    i_flush = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h4444; s_axis_tlast = 1'b1;
    #1;
    check("flush_tready", s_axis_tready, 0);
    tick();
    i_flush = 1'b0; s_axis_tvalid = 1'b0;
    sb.delete();
    check("flush_valid", o_byte_valid, 0);
    check("flush_words", o_words, 0);
    send(16'h1234, 1'b1);
    tick();
    check("post_flush_byte0", o_byte, 8'h34);
    drain(10);

    // Asynchronous reset mid-stream.
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hCCCC;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tready", s_axis_tready, 0);
    check("async_rst_valid", o_byte_valid, 0);
    check("async_rst_words", o_words, 0);
    s_axis_tvalid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    sb.delete();
    check("async_rel_tready", s_axis_tready, 1);
    check("async_rel_words", o_words, 0);
    @(posedge clk); #1;

`ifdef AXIS_SLAVE_BYTE_FIFO_TKEEP_EN
    tb_keep = 2'b10;
    send(16'hBBAA, 1'b1);
    tick();
    check("keep_hi_byte", o_byte, 8'hBB);
    check("keep_hi_last", o_byte_last, 1);
    drain(10);
    tb_keep = 2'b00;
    send(16'h5A5A, 1'b1);
    tick();
    check("keep_zero_byte", o_byte, 8'h00);
    check("keep_zero_last", o_byte_last, 1);
    drain(10);
    send(16'h5A5A, 1'b0);
    check("keep_drop_words", o_words, 0);
    tick();
    check("keep_drop_valid", o_byte_valid, 0);
    tb_keep = '1;
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
